// File: rtl/tt_sweep_checker.sv
// Exhaustive sweep checker: steps stim through every input vector, compares resp_in with TRUTH.
// Optional SWEEP_MISS_MAP_EN adds a per-vector miss bitmap output.
module tt_sweep_checker #(
  parameter int                    N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0]  TRUTH  = 8'hCA,
  parameter int                    SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_IN-1:0]     stim,
  input  logic                resp_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     first_err,
  output logic                first_err_v
`ifdef SWEEP_MISS_MAP_EN
  ,
  output logic [(1<<N_IN)-1:0] miss_map
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  localparam logic [N_IN-1:0] LAST   = '1;
  localparam logic [3:0]      SET_L  = 4'(SETTLE);
  // With no settle time each vector goes straight to its sample cycle.
  localparam state_t          RUN_ST = (SETTLE == 0) ? SAMPLE : HOLD;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            accept, do_sample, last, mismatch;
  logic [N_IN:0]   err_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = RUN_ST;
      HOLD:       if (cnt == 4'd1) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last ? DONE : RUN_ST;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    do_sample = (state == SAMPLE);
    last      = (stim == LAST);
    mismatch  = do_sample && (resp_in != TRUTH[stim]);
    err_nxt   = err_count + (N_IN+1)'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_err   <= '0;
      first_err_v <= 1'b0;
      cnt         <= '0;
`ifdef SWEEP_MISS_MAP_EN
      miss_map    <= '0;
`endif
    end else if (accept) begin
      stim        <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_err   <= '0;
      first_err_v <= 1'b0;
      cnt         <= SET_L;
`ifdef SWEEP_MISS_MAP_EN
      miss_map    <= '0;
`endif
    end else begin
      if (state == HOLD) cnt <= cnt - 4'd1;
      if (do_sample) begin
        err_count <= err_nxt;
        if (mismatch && !first_err_v) begin
          first_err   <= stim;
          first_err_v <= 1'b1;
        end
`ifdef SWEEP_MISS_MAP_EN
        if (mismatch) miss_map[stim] <= 1'b1;
`endif
        // Final vector: stim parks on its last value, results latch until next start.
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end else begin
          stim <= stim + N_IN'(1);
          cnt  <= SET_L;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a cycle-timed sweep model checks every cycle,
// plus literal expectations per scenario. Instance a uses SETTLE=2, instance b SETTLE=0.
module tb_tt_sweep_checker;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] stim_a, stim_b, fe_a, fe_b;
  logic       resp_a, resp_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
  logic [3:0] err_a, err_b;
`ifdef SWEEP_MISS_MAP_EN
  logic [7:0] map_a, map_b;
`endif
  int mode_a = 0, mode_b = 0;
  int n_vec = 0, n_miss = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // f = xy + yz + x'z straight from the formula, not from the 8'hCA table
  function automatic bit good(input int s);
    logic [2:0] v;
    v = 3'(s);
    return (v[2] & v[1]) | (v[1] & v[0]) | (~v[2] & v[0]);
  endfunction

  // mode 0: healthy function, 1: output stuck at 0, 2: fault only at vector 5
  function automatic bit resp_fn(input int mode, input int s);
    case (mode)
      1:       return 1'b0;
      2:       return (s == 5) ? 1'b1 : good(s);
      default: return good(s);
    endcase
  endfunction

  assign resp_a = resp_fn(mode_a, int'(stim_a));
  assign resp_b = resp_fn(mode_b, int'(stim_b));

  tt_sweep_checker #(.N_IN(3), .TRUTH(8'hCA), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .resp_in(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err(fe_a), .first_err_v(fv_a)
`ifdef SWEEP_MISS_MAP_EN
    , .miss_map(map_a)
`endif
  );

  tt_sweep_checker #(.N_IN(3), .TRUTH(8'hCA), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .resp_in(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err(fe_b), .first_err_v(fv_b)
`ifdef SWEEP_MISS_MAP_EN
    , .miss_map(map_b)
`endif
  );

  typedef struct {
    bit busy, done, pass, fv;
    int stim, err, first, t;
    bit [7:0] map;
  } mdl_t;

  mdl_t m[2];
  int   settle[2] = '{2, 0};

  // Time-based model: cycle t of a sweep samples vector t/(S+1) on its last phase.
  task automatic step(input int i, input bit r, input bit st, input int mode);
    if (r) begin
      m[i].busy = 0; m[i].done = 0; m[i].pass = 0; m[i].fv = 0;
      m[i].stim = 0; m[i].err = 0; m[i].first = 0; m[i].t = 0; m[i].map = 0;
    end else if (st && !m[i].busy) begin
      m[i].busy = 1; m[i].done = 0; m[i].pass = 0; m[i].fv = 0;
      m[i].stim = 0; m[i].err = 0; m[i].first = 0; m[i].t = 0; m[i].map = 0;
    end else if (m[i].busy) begin
      if (m[i].t % (settle[i] + 1) == settle[i]) begin
        if (resp_fn(mode, m[i].stim) != good(m[i].stim)) begin
          m[i].err++;
          m[i].map[m[i].stim] = 1'b1;
          if (!m[i].fv) begin m[i].first = m[i].stim; m[i].fv = 1; end
        end
        if (m[i].stim == 7) begin
          m[i].busy = 0; m[i].done = 1; m[i].pass = (m[i].err == 0);
        end else m[i].stim++;
      end
      m[i].t++;
    end
  endtask

  always @(posedge clk) begin
    step(0, rst, start_a, mode_a);
    step(1, rst, start_b, mode_b);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("a.stim", 32'(stim_a), m[0].stim);  check("a.busy", 32'(busy_a), m[0].busy);
    check("a.done", 32'(done_a), m[0].done);  check("a.pass", 32'(pass_a), m[0].pass);
    check("a.err",  32'(err_a),  m[0].err);   check("a.fe",   32'(fe_a),   m[0].first);
    check("a.fv",   32'(fv_a),   m[0].fv);
    check("b.stim", 32'(stim_b), m[1].stim);  check("b.busy", 32'(busy_b), m[1].busy);
    check("b.done", 32'(done_b), m[1].done);  check("b.pass", 32'(pass_b), m[1].pass);
    check("b.err",  32'(err_b),  m[1].err);   check("b.fe",   32'(fe_b),   m[1].first);
    check("b.fv",   32'(fv_b),   m[1].fv);
`ifdef SWEEP_MISS_MAP_EN
    check("a.map", 32'(map_a), 32'(m[0].map));
    check("b.map", 32'(map_b), 32'(m[1].map));
`endif
  end

  // Pulse start on instance a; returns at the first busy cycle.
  task automatic kick_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (!done_a && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  initial begin
    int cyc;
    bit pulsed;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset.stim", 32'(stim_a), 0);
    check("reset.done", 32'(done_a), 0);
    check("reset.err",  32'(err_a),  0);

    // 1: healthy function
    @(negedge clk);
    kick_a();
    check("s1.busy", 32'(busy_a), 1);
    wait_done_a(cyc);
    check("s1.len",  cyc, 24);
    check("s1.pass", 32'(pass_a), 1);
    check("s1.err",  32'(err_a), 0);
    check("s1.fv",   32'(fv_a), 0);
    check("s1.stim_parked", 32'(stim_a), 7);

    // 2: output stuck at 0; start from DONE clears results
    repeat (3) @(negedge clk);
    mode_a = 1;
    kick_a();
    check("s2.clr_err",  32'(err_a), 0);
    check("s2.clr_done", 32'(done_a), 0);
    wait_done_a(cyc);
    check("s2.len",  cyc, 24);
    check("s2.err",  32'(err_a), 4);
    check("s2.fe",   32'(fe_a), 1);
    check("s2.fv",   32'(fv_a), 1);
    check("s2.pass", 32'(pass_a), 0);
`ifdef SWEEP_MISS_MAP_EN
    check("s2.map",  32'(map_a), 32'h0000_00CA);
`endif

    // 3: single fault at vector 5
    mode_a = 2;
    kick_a();
    wait_done_a(cyc);
    check("s3.err",  32'(err_a), 1);
    check("s3.fe",   32'(fe_a), 5);
    check("s3.pass", 32'(pass_a), 0);
`ifdef SWEEP_MISS_MAP_EN
    check("s3.map",  32'(map_a), 32'h0000_0020);
`endif

    // 4: start re-pulsed mid-sweep at stim=3 is ignored
    mode_a = 0;
    kick_a();
    cyc = 0; pulsed = 0;
    while (!done_a && cyc < 200) begin
      if (stim_a == 3 && !pulsed) begin start_a = 1'b1; pulsed = 1; end
      else start_a = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    check("s4.pulsed", 32'(pulsed), 1);
    check("s4.len",  cyc, 24);
    check("s4.pass", 32'(pass_a), 1);

    // 5: reset mid-sweep at stim=4 aborts, no done until a new start
    mode_a = 1;
    kick_a();
    cyc = 0;
    while (stim_a != 3'd4 && cyc < 200) begin @(negedge clk); cyc++; end
    check("s5.reach4", 32'(stim_a), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5.busy", 32'(busy_a), 0);
    check("s5.stim", 32'(stim_a), 0);
    check("s5.err",  32'(err_a), 0);
    check("s5.fv",   32'(fv_a), 0);
    repeat (40) @(negedge clk);
    check("s5.nodone", 32'(done_a), 0);

    // 6: SETTLE=0 instance, one vector per cycle
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("s6.busy", 32'(busy_b), 1);
    cyc = 0;
    while (!done_b && cyc < 200) begin @(negedge clk); cyc++; end
    check("s6.len",  cyc, 8);
    check("s6.pass", 32'(pass_b), 1);
    check("s6.err",  32'(err_b), 0);
    check("s6.fv",   32'(fv_b), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
